// File: rtl/normal_multiplier_pkg.sv
// rtl/normal_multiplier_pkg.sv - shared constants for the multiplier blocks
package normal_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int PRODUCT_WIDTH = 2 * DEFAULT_WIDTH;

    function automatic int product_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/normal_multiplier_full_adder.sv
// rtl/normal_multiplier_full_adder.sv - single-bit full adder cell of the array
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/normal_multiplier.sv
// rtl/normal_multiplier.sv - registered unsigned array multiplier, one product per cycle
module normal_multiplier
    import normal_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    output logic [product_width(WIDTH)-1:0]     out
);

    localparam int PW = product_width(WIDTH);

    logic [WIDTH-1:0] pp        [WIDTH];
    logic [WIDTH-1:0] row_in    [WIDTH];
    logic [WIDTH-1:0] row_sum   [1:WIDTH-1];
    logic [WIDTH-1:0] row_carry [1:WIDTH-1];
    logic [PW-1:0]    product;

    genvar i, j;

    for (i = 0; i < WIDTH; i++) begin : g_pp
        assign pp[i] = a & {WIDTH{b[i]}};
    end

    // row_in[k] carries the upper WIDTH bits of the running sum into row k+1
    assign product[0] = pp[0][0];
    assign row_in[0]  = {1'b0, pp[0][WIDTH-1:1]};

    for (i = 1; i < WIDTH; i++) begin : g_row
        for (j = 0; j < WIDTH; j++) begin : g_fa
            if (j == 0) begin : g_first
                full_adder u_fa (
                    .x    (pp[i][j]),
                    .y    (row_in[i-1][j]),
                    .cin  (1'b0),
                    .s    (row_sum[i][j]),
                    .cout (row_carry[i][j])
                );
            end else begin : g_rest
                full_adder u_fa (
                    .x    (pp[i][j]),
                    .y    (row_in[i-1][j]),
                    .cin  (row_carry[i][j-1]),
                    .s    (row_sum[i][j]),
                    .cout (row_carry[i][j])
                );
            end
        end
        assign product[i] = row_sum[i][0];
        assign row_in[i]  = {row_carry[i][WIDTH-1], row_sum[i][WIDTH-1:1]};
    end

    // last row's carry lands in the product MSB
    assign product[PW-1:WIDTH] = row_in[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= product;
        end
    end

endmodule

// File: tb/tb_normal_multiplier.sv
// tb/tb_normal_multiplier.sv - randomized and directed checks of normal_multiplier
module tb_normal_multiplier;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a   = 4'd0;
    logic [3:0] b   = 4'd0;
    logic [7:0] out;

    int tests    = 0;
    int failures = 0;
    logic [7:0] last_exp = 8'd0;

    normal_multiplier #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .out (out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // drive on the falling edge, confirm out holds, then check the registered product
    task automatic step(input logic [3:0] ai, input logic [3:0] bi, input string tag);
        @(negedge clk);
        a = ai;
        b = bi;
        #1;
        check({tag, "_hold"}, out, last_exp);
        @(posedge clk);
        #1;
        last_exp = model(ai, bi);
        check(tag, out, last_exp);
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'd12;
        b   = 4'd13;
        #1;
        check("reset_async", out, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", out, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        last_exp = model(4'd12, 4'd13);
        check("release_first", out, 8'd156);
        check("release_model", out, last_exp);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                step(4'(ia), 4'(ib), $sformatf("sweep_%0d_%0d", ia, ib));
            end
        end

        step(4'd15, 4'd15, "ones_x_ones");
        check("ones_const", out, 8'd225);
        step(4'd0, 4'd15, "zero_a");
        check("zero_a_const", out, 8'd0);
        step(4'd1, 4'd9, "one_a");
        check("one_a_const", out, 8'd9);

        for (int k = 0; k < 200; k++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $sformatf("rand_%0d", k));
        end

        step(4'd3, 4'd5, "b2b_0");
        check("b2b_0_const", out, 8'd15);
        step(4'd7, 4'd7, "b2b_1");
        check("b2b_1_const", out, 8'd49);
        step(4'd15, 4'd1, "b2b_2");
        check("b2b_2_const", out, 8'd15);

        step(4'd15, 4'd15, "pre_reset");
        #3;
        rst = 1'b1;
        #1;
        check("reset_midcycle", out, 8'd0);
        @(posedge clk);
        #1;
        check("reset_hold_edge", out, 8'd0);
        @(negedge clk);
        a   = 4'd6;
        b   = 4'd7;
        rst = 1'b0;
        #1;
        check("reset_release_hold", out, 8'd0);
        @(posedge clk);
        #1;
        last_exp = model(4'd6, 4'd7);
        check("reset_release", out, last_exp);

        @(negedge clk);
        a = 4'd12;
        b = 4'd13;
        #1;
        check("glitch_0", out, last_exp);
        a = 4'd4;
        #1;
        check("glitch_1", out, last_exp);
        a = 4'd12;
        @(posedge clk);
        #1;
        last_exp = model(4'd12, 4'd13);
        check("glitch_edge", out, 8'd156);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
